// File: rtl/register_unit.sv
// register_unit: 32 x XLEN integer register file for the monocycle RISC-V core.
// Two combinational operand read ports feed the ALU source muxes, a third
// combinational port serves debug/display, and a 16-bit counter tallies
// committed writes. x0 reads as zero and ignores writes.
module register_unit #(
  parameter int              XLEN    = 32,
  parameter logic [XLEN-1:0] SP_INIT = 32'h0000_03FC,
  parameter logic [XLEN-1:0] GP_INIT = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             rs1,
  input  logic [4:0]             rs2,
  input  logic [4:0]             rd,
  input  logic                   ru_wr,
  input  logic signed [XLEN-1:0] data_wr,
  output logic signed [XLEN-1:0] ru_rs1,
  output logic signed [XLEN-1:0] ru_rs2,
  input  logic [4:0]             dbg_addr,
  output logic [XLEN-1:0]        dbg_data,
  output logic [15:0]            wr_count
);

  logic signed [XLEN-1:0] regs_q [32];
  logic signed [XLEN-1:0] regs_d [32];
  logic [15:0]            cnt_q;
  logic [15:0]            cnt_d;
  logic                   commit;

  // A write commits only when enabled and aimed at a real register; this
  // gate also keeps an undriven rd/data_wr from touching state while idle.
  assign commit = ru_wr && (rd != 5'd0);

  // Next-state: copy current contents, overwrite the addressed entry and
  // bump the counter on a committed write. The counter wraps naturally.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      regs_d[i] = regs_q[i];
    end
    cnt_d = cnt_q;
    if (commit) begin
      regs_d[rd] = data_wr;
      cnt_d      = cnt_q + 16'd1;
    end
    regs_d[0] = '0;
  end

  // State update: reset wins over any write in the same cycle and restores
  // the ABI start-up values for sp and gp.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      regs_q[2] <= SP_INIT;
      regs_q[3] <= GP_INIT;
      cnt_q     <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
      cnt_q <= cnt_d;
    end
  end

  // Read ports: zero-latency, no write bypass, so a same-cycle read returns
  // the pre-edge value. Address 0 is forced to zero explicitly.
  always_comb begin
    ru_rs1   = (rs1 == 5'd0)      ? '0 : regs_q[rs1];
    ru_rs2   = (rs2 == 5'd0)      ? '0 : regs_q[rs2];
    dbg_data = (dbg_addr == 5'd0) ? '0 : regs_q[dbg_addr];
  end

  assign wr_count = cnt_q;

endmodule

// File: doc/register_unit.md
Name: register_unit

Overview:
- 32 x 32-bit RISC-V integer register file for the monocycle core, directly upstream of the ALU A/B source muxes.
- Supplies ru_rs1 (consumed by the ALU A-source mux, alongside pc) and ru_rs2 (B-source mux, store data).
- Accepts the writeback result at the clock edge that ends each instruction.
- Also provides a debug read port and a write counter for benches and the board display.

Parameters:
- XLEN, 32, data width of every register.
- SP_INIT, 32'h0000_03FC, reset value of x2 (sp); top of data memory.
- GP_INIT, 32'h0000_0000, reset value of x3 (gp).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- rs1  input  5  read address A.
- rs2  input  5  read address B.
- rd  input  5  write address.
- ru_wr  input  1  write enable.
- data_wr  input  XLEN  writeback data, signed.
- ru_rs1  output  XLEN  register[rs1], signed.
- ru_rs2  output  XLEN  register[rs2], signed.
- dbg_addr  input  5  debug read address.
- dbg_data  output  XLEN  register[dbg_addr].
- wr_count  output  16  count of committed writes.

Behaviour:
- Storage: 32 registers of XLEN bits; x0 is hardwired to zero.
- Reset: rst=1 sampled at a rising edge does the following.
  - Loads x2=SP_INIT, x3=GP_INIT, all other registers 0, and wr_count=0.
  - Reset overrides ru_wr in the same cycle; the write is dropped.
  - Reset asserted mid-program discards all state on that edge.
  - ru_rs1, ru_rs2 and dbg_data reflect the reset contents combinationally from the next cycle on.
- Reads: ru_rs1, ru_rs2 and dbg_data are purely combinational (0-cycle latency) from the current register contents.
  - Address 0 always returns 0.
  - The three read ports are independent; identical addresses are allowed.
- Write: on a rising edge with rst=0, ru_wr=1 and rd!=0, register[rd] is set to data_wr.
  - The new value is visible on the read ports after that edge, not before.
  - No internal bypass is required: a monocycle read in the same cycle returns the old value.
- Write to x0 (ru_wr=1, rd=0): no state change and wr_count is not incremented.
- wr_count increments by 1 on each committed write (rd!=0, ru_wr=1, rst=0).
  - It wraps from 16'hFFFF to 16'h0000 with no flag.
- ru_wr=0: no register or counter change, whatever the values of rd and data_wr.
- X handling: with ru_wr=0, X on rd or data_wr must not corrupt state.
- Width rules: no sign extension or truncation inside the block; data is stored bit-exact.

Test Plan:
- Reset values.
  - Stimulus: rst=1 for one edge, then read every address via rs1, rs2 and dbg_addr.
  - Required: x2=0x000003FC, x3=0, all others 0, wr_count=0.
- Write and readback.
  - Stimulus: ru_wr=1, rd=5, data_wr=0xFFFFFFF0 for one edge; then rs1=5, rs2=5.
  - Required: before the edge ru_rs1=0; after it ru_rs1=ru_rs2=0xFFFFFFF0 and wr_count=1.
- x0 protection.
  - Stimulus: ru_wr=1, rd=0, data_wr=0x12345678 for one edge.
  - Required: ru_rs1 with rs1=0 returns 0 and wr_count is unchanged.
- Write enable low.
  - Stimulus: ru_wr=0, rd=7, data_wr=0x7FFFFFFF for one edge.
  - Required: x7 stays 0 and wr_count is unchanged.
- Reset during write.
  - Stimulus: x10=0x00000100 written earlier; assert rst=1 together with ru_wr=1, rd=10, data_wr=0xAAAAAAAA.
  - Required: after the edge x10=0, x2=0x000003FC, wr_count=0.
- Counter wrap and back-to-back writes.
  - Stimulus: perform 65536 writes cycling rd through 1..31 with data_wr=cycle index.
  - Required: wr_count returns to 0.
  - Required: each register holds the last value written to it, checked via dbg_data.
